// File: rtl/sparse_stream_sink.sv
// sparse_stream_sink
// Receive end of the 17-bit sparse ready/valid token stream. It applies
// programmable backpressure, classifies incoming tokens as data, stop, done
// or illegal, keeps counters and a payload checksum, captures every accepted
// token into a readable buffer, and raises done once the expected number of
// done tokens has arrived.
//
// Optional feature: define SPARSE_SINK_CYCLE_COUNT_EN to build the cycle
// counter. When it is undefined, cycle_count is tied to zero.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   clk_en            global enable; when low every register holds
//   flush             synchronous clear of counters, buffer pointer and FSM
//   tile_en           block enable; low forces IDLE and drops ready
//   cfg_num_tx        done tokens expected (0 is treated as 1)
//   cfg_ready_mode    0 always, 1 LFSR random, 2 alternate, 3 never ready
//   cfg_seed          LFSR seed (0 is replaced by 16'hACE1)
//   stream_in*        token input with valid/ready handshake
//   done              all expected done tokens received
//   data_count        accepted data tokens
//   stop_count        accepted stop tokens
//   checksum          sum of data payloads mod 2^16
//   error             sticky: illegal control token or buffer overflow
//   rd_addr, rd_data  combinational buffer read port
//   wr_count          entries captured, saturating at DEPTH
//   cycle_count       active cycles from first transfer until done
module sparse_stream_sink #(
    parameter int                DATA_W     = 17,
    parameter int                DEPTH      = 64,
    parameter logic [DATA_W-1:0] DONE_TOKEN = 17'h10100,
    localparam int               AW         = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clk_en,
    input  logic              flush,
    input  logic              tile_en,
    input  logic [7:0]        cfg_num_tx,
    input  logic [1:0]        cfg_ready_mode,
    input  logic [15:0]       cfg_seed,
    input  logic [DATA_W-1:0] stream_in,
    input  logic              stream_in_valid,
    output logic              stream_in_ready,
    output logic              done,
    output logic [15:0]       data_count,
    output logic [15:0]       stop_count,
    output logic [15:0]       checksum,
    output logic              error,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic [AW:0]       wr_count,
    output logic [31:0]       cycle_count
);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

    state_t            state_q, state_d;
    logic [15:0]       lfsr_q, lfsr_d;
    logic              toggle_q, toggle_d;
    logic [15:0]       data_count_q, data_count_d;
    logic [15:0]       stop_count_q, stop_count_d;
    logic [15:0]       checksum_q, checksum_d;
    logic [7:0]        done_cnt_q, done_cnt_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic [AW:0]       wr_count_q, wr_count_d;
    logic              mem_we;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic        xfer;
    logic        is_data, is_stop, is_done_tok, is_illegal;
    logic [7:0]  num_tx_eff;
    logic [15:0] seed_eff;
    logic        lfsr_fb;
    logic        done_reached;
    logic        buf_full;
    logic        pattern;

    assign xfer        = stream_in_valid & stream_in_ready;
    assign is_data     = ~stream_in[16];
    assign is_stop     = stream_in[16] & (stream_in[9:8] == 2'b00);
    assign is_done_tok = (stream_in == DONE_TOKEN);
    assign is_illegal  = stream_in[16] & ~is_stop & ~is_done_tok;
    assign num_tx_eff  = (cfg_num_tx == 8'd0) ? 8'd1 : cfg_num_tx;
    assign seed_eff    = (cfg_seed == 16'd0) ? 16'hACE1 : cfg_seed;
    // Fibonacci taps 16,14,13,11 shifting toward the MSB; bit 0 is the pattern.
    assign lfsr_fb     = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
    assign done_reached = ({1'b0, done_cnt_q} + 9'd1) >= {1'b0, num_tx_eff};
    // wr_count saturates at DEPTH (a power of two), so its MSB marks full.
    assign buf_full    = wr_count_q[AW];

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else if (clk_en) begin
            state_q <= state_d;
        end
    end

    // Next-state logic. Re-entering from IDLE with done already set goes
    // straight back to DONE so no further tokens are accepted.
    always_comb begin
        state_d = state_q;
        if (flush || !tile_en) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: state_d = done_q ? ST_DONE : ST_RUN;
                ST_RUN:  if (xfer && is_done_tok && done_reached) state_d = ST_DONE;
                default: state_d = ST_DONE;
            endcase
        end
    end

    // Output logic: backpressure pattern and handshake ready.
    always_comb begin
        pattern = 1'b0;
        case (cfg_ready_mode)
            2'd0:    pattern = 1'b1;
            2'd1:    pattern = lfsr_q[0];
            2'd2:    pattern = toggle_q;
            default: pattern = 1'b0;
        endcase
        stream_in_ready = (state_q == ST_RUN) & tile_en & clk_en & pattern;
    end

    // Datapath. IDLE keeps reloading the seed and the toggle so both start
    // fresh on RUN entry. Flush overrides any simultaneous transfer.
    always_comb begin
        lfsr_d       = lfsr_q;
        toggle_d     = toggle_q;
        data_count_d = data_count_q;
        stop_count_d = stop_count_q;
        checksum_d   = checksum_q;
        done_cnt_d   = done_cnt_q;
        done_d       = done_q;
        error_d      = error_q;
        wr_count_d   = wr_count_q;
        mem_we       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                lfsr_d   = seed_eff;
                toggle_d = 1'b1;
            end
            ST_RUN: begin
                lfsr_d   = {lfsr_q[14:0], lfsr_fb};
                toggle_d = ~toggle_q;
            end
            default: ;
        endcase

        if (flush) begin
            lfsr_d       = seed_eff;
            toggle_d     = 1'b1;
            data_count_d = 16'd0;
            stop_count_d = 16'd0;
            checksum_d   = 16'd0;
            done_cnt_d   = 8'd0;
            done_d       = 1'b0;
            error_d      = 1'b0;
            wr_count_d   = '0;
        end else if (xfer) begin
            if (is_data) begin
                data_count_d = data_count_q + 16'd1;
                checksum_d   = checksum_q + stream_in[15:0];
            end
            if (is_stop) begin
                stop_count_d = stop_count_q + 16'd1;
            end
            if (is_done_tok) begin
                if (done_cnt_q != 8'hFF) done_cnt_d = done_cnt_q + 8'd1;
                if (done_reached) done_d = 1'b1;
            end
            if (is_illegal) begin
                error_d = 1'b1;
            end
            if (buf_full) begin
                error_d = 1'b1;
            end else begin
                mem_we     = 1'b1;
                wr_count_d = wr_count_q + 1'b1;
            end
        end
    end

    // Counter and status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q       <= 16'hACE1;
            toggle_q     <= 1'b1;
            data_count_q <= 16'd0;
            stop_count_q <= 16'd0;
            checksum_q   <= 16'd0;
            done_cnt_q   <= 8'd0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            wr_count_q   <= '0;
        end else if (clk_en) begin
            lfsr_q       <= lfsr_d;
            toggle_q     <= toggle_d;
            data_count_q <= data_count_d;
            stop_count_q <= stop_count_d;
            checksum_q   <= checksum_d;
            done_cnt_q   <= done_cnt_d;
            done_q       <= done_d;
            error_q      <= error_d;
            wr_count_q   <= wr_count_d;
        end
    end

    // Capture buffer; contents are not reset. mem_we already implies clk_en.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[wr_count_q[AW-1:0]] <= stream_in;
        end
    end

`ifdef SPARSE_SINK_CYCLE_COUNT_EN
    logic [31:0] cycle_q, cycle_d;
    logic        started_q, started_d;

    // Counts from the first transfer (inclusive) until done is set.
    always_comb begin
        cycle_d   = cycle_q;
        started_d = started_q;
        if (flush) begin
            cycle_d   = 32'd0;
            started_d = 1'b0;
        end else begin
            if (xfer) started_d = 1'b1;
            if (!done_q && (started_q || xfer)) cycle_d = cycle_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_q   <= 32'd0;
            started_q <= 1'b0;
        end else if (clk_en) begin
            cycle_q   <= cycle_d;
            started_q <= started_d;
        end
    end

    assign cycle_count = cycle_q;
`else
    assign cycle_count = 32'd0;
`endif

    assign done       = done_q;
    assign data_count = data_count_q;
    assign stop_count = stop_count_q;
    assign checksum   = checksum_q;
    assign error      = error_q;
    assign wr_count   = wr_count_q;
    assign rd_data    = mem_q[rd_addr];

endmodule
